// File: rtl/logic_unit_pkg.sv
// Shared types for the arbitrated bitwise logic unit: opcodes, FSM states
// and the opcode field width.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_NOT     = 3'd2,
    OP_NAND    = 3'd3,
    OP_NOR     = 3'd4,
    OP_XOR     = 3'd5,
    OP_XNOR    = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic unit built from per-bit gate primitives,
// with an opcode mux selecting the result and flagging illegal opcodes.
module logic_op_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  logic [WIDTH-1:0] y_and;
  logic [WIDTH-1:0] y_or;
  logic [WIDTH-1:0] y_not;
  logic [WIDTH-1:0] y_nand;
  logic [WIDTH-1:0] y_nor;
  logic [WIDTH-1:0] y_xor;
  logic [WIDTH-1:0] y_xnor;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and  u_and  (y_and[i],  a[i], b[i]);
    or   u_or   (y_or[i],   a[i], b[i]);
    not  u_not  (y_not[i],  a[i]);
    nand u_nand (y_nand[i], a[i], b[i]);
    nor  u_nor  (y_nor[i],  a[i], b[i]);
    xor  u_xor  (y_xor[i],  a[i], b[i]);
    xnor u_xnor (y_xnor[i], a[i], b[i]);
  end

  // Opcode 7 yields a zero result with the error flag raised
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op_e'(op))
      OP_AND:  y = y_and;
      OP_OR:   y = y_or;
      OP_NOT:  y = y_not;
      OP_NAND: y = y_nand;
      OP_NOR:  y = y_nor;
      OP_XOR:  y = y_xor;
      OP_XNOR: y = y_xnor;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit among NUM_REQ requesters,
// with a registered result stage on a valid/ready response channel.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*WIDTH-1:0]  req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      rsp_err
);

  state_e           state_q;
  state_e           state_d;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_ptr_d;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic             grant_found;
  logic             accept_en;
  logic             handshake;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] op_y;
  logic             op_err;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept_en = (state_q == ST_IDLE) || rsp_ready;
  assign handshake = rst_n && accept_en && grant_found;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_op = req_op[i*OP_W +: OP_W];
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  logic_op_unit #(
    .WIDTH (WIDTH)
  ) u_op_unit (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .y   (op_y),
    .err (op_err)
  );

  // A grant while draining the output keeps the FSM in RESP for back-to-back results
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    case (state_q)
      ST_IDLE: if (handshake) state_d = ST_RESP;
      ST_RESP: if (rsp_ready && !handshake) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        rr_ptr   <= rr_ptr_d;
        rsp_id   <= grant_idx;
        rsp_data <= op_y;
        rsp_err  <= op_err;
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: table-driven op vectors plus
// hand-written backpressure, wrap, reset and round-robin sequences.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         req;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] data;
    logic       err;
  } vec_t;

  vec_t vecs[9];
  int   rr_order[6];

  logic_unit_arbiter #(
    .NUM_REQ (4),
    .WIDTH   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task applyStimulus(input int idx, input logic v, input logic [2:0] op,
                     input logic [7:0] a, input logic [7:0] b);
    req_valid[idx]       = v;
    req_op[idx*3 +: 3]   = op;
    req_a[idx*8 +: 8]    = a;
    req_b[idx*8 +: 8]    = b;
  endtask

  task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    vecs[0] = '{2, 3'd0, 8'hC5, 8'h3A, 8'h00, 1'b0};
    vecs[1] = '{2, 3'd1, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    vecs[2] = '{2, 3'd2, 8'hC5, 8'h3A, 8'h3A, 1'b0};
    vecs[3] = '{2, 3'd3, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    vecs[4] = '{2, 3'd4, 8'hC5, 8'h3A, 8'h00, 1'b0};
    vecs[5] = '{2, 3'd5, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    vecs[6] = '{2, 3'd6, 8'hC5, 8'h3A, 8'h00, 1'b0};
    vecs[7] = '{0, 3'd7, 8'hA5, 8'h5A, 8'h00, 1'b1};
    vecs[8] = '{0, 3'd0, 8'hF3, 8'h3C, 8'h30, 1'b0};
    rr_order = '{0, 1, 2, 3, 0, 1};

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset, then idle for ten cycles
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("idle_req_ready", 32'(req_ready), 32'd0);
      checkOutput("idle_rsp_data", 32'(rsp_data), 32'd0);
    end

    // Table-driven op sweep and illegal-opcode vectors
    for (int n = 0; n < 9; n++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[n].req, 1'b1, vecs[n].op, vecs[n].a, vecs[n].b);
      @(negedge clk);
      checkOutput("vec_req_ready", 32'(req_ready), 32'(4'b0001 << vecs[n].req));
      @(posedge clk); #1;
      applyStimulus(vecs[n].req, 1'b0, 3'd0, 8'h00, 8'h00);
      @(negedge clk);
      checkOutput("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("vec_rsp_id", 32'(rsp_id), 32'(vecs[n].req));
      checkOutput("vec_rsp_data", 32'(rsp_data), 32'(vecs[n].data));
      checkOutput("vec_rsp_err", 32'(rsp_err), 32'(vecs[n].err));
    end

    // Backpressure: requester 1 held while requester 3 waits
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 3'd5, 8'hF0, 8'h0F);
    @(negedge clk);
    checkOutput("bp_grant1", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 3'd0, 8'h00, 8'h00);
    applyStimulus(3, 1'b1, 3'd0, 8'hFF, 8'h0F);
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_data", 32'(rsp_data), 32'hFF);
      checkOutput("bp_rsp_id", 32'(rsp_id), 32'd1);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
    end
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_grant3", 32'(req_ready), 32'b1000);
    checkOutput("bp_release_data", 32'(rsp_data), 32'hFF);
    @(posedge clk); #1;
    applyStimulus(3, 1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("bp_next_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_next_id", 32'(rsp_id), 32'd3);
    checkOutput("bp_next_data", 32'(rsp_data), 32'h0F);

    // Pointer wrap: move rr_ptr to 3, then requesters 3 and 0 contend
    @(posedge clk); #1;
    applyStimulus(2, 1'b1, 3'd0, 8'hFF, 8'hFF);
    @(negedge clk);
    checkOutput("wrap_grant2", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    applyStimulus(2, 1'b0, 3'd0, 8'h00, 8'h00);
    applyStimulus(3, 1'b1, 3'd0, 8'hFF, 8'hFF);
    applyStimulus(0, 1'b1, 3'd0, 8'hFF, 8'hFF);
    @(negedge clk);
    checkOutput("wrap_grant3", 32'(req_ready), 32'b1000);
    checkOutput("wrap_id2", 32'(rsp_id), 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("wrap_grant0", 32'(req_ready), 32'b0001);
    checkOutput("wrap_id3", 32'(rsp_id), 32'd3);
    @(posedge clk); #1;
    applyStimulus(3, 1'b0, 3'd0, 8'h00, 8'h00);
    applyStimulus(1, 1'b1, 3'd0, 8'hFF, 8'hFF);
    @(negedge clk);
    checkOutput("wrap_id0", 32'(rsp_id), 32'd0);
    checkOutput("wrap_ptr1_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 3'd0, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("wrap_id1", 32'(rsp_id), 32'd1);

    // Reset while a response is held
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    applyStimulus(0, 1'b1, 3'd0, 8'hFF, 8'hFF);
    @(negedge clk);
    checkOutput("rst_grant0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 3'd0, 8'h00, 8'h00);
    applyStimulus(1, 1'b1, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rst_pre_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rst_pre_data", 32'(rsp_data), 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_async_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_async_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_async_id", 32'(rsp_id), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hold_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_hold_ready", 32'(req_ready), 32'd0);
    #2;
    applyStimulus(1, 1'b0, 3'd0, 8'h00, 8'h00);
    rsp_ready = 1'b1;
    rst_n     = 1'b1;

    // Round-robin with all requesters continuously valid
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 3'd1, 8'(8'h10 + i), 8'h00);
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (n < 6) checkOutput("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_order[n]));
      if (n > 0) begin
        checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rr_rsp_id", 32'(rsp_id), 32'(rr_order[n-1]));
        checkOutput("rr_rsp_data", 32'(rsp_data), 32'(8'h10 + rr_order[n-1]));
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) among NUM_REQ requesters.
- Grants requesters round-robin and computes the selected operation in a registered stage.
- Returns the result with the requester ID over a valid/ready response channel that supports backpressure.
- Sits between client blocks and the shared gate datapath, so each client needs no private logic unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_op  input  NUM_REQ*3  per-requester opcode, requester i at bits [3i+2:3i].
- req_a  input  NUM_REQ*WIDTH  per-requester operand A, slice i.
- req_b  input  NUM_REQ*WIDTH  per-requester operand B, slice i (ignored for NOT).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester served.
- rsp_data  output  WIDTH  operation result.
- rsp_err  output  1  set when the opcode was illegal.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, rr_ptr=0, state=IDLE. req_ready is combinational and is 0 while rst_n=0.
- Opcodes: 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR. All are bitwise over WIDTH bits.
- Illegal opcode 7: result 0, rsp_err=1. The request is still accepted and answered.
- FSM has two states:
  - IDLE: output register empty, rsp_valid=0.
  - RESP: output register holds a result, rsp_valid=1.
- accept_en = (state==IDLE) || (state==RESP && rsp_ready).
- Arbitration is combinational, evaluated every cycle:
  - Search req_valid starting at index rr_ptr, ascending, wrapping modulo NUM_REQ. The first set bit is the winner.
  - req_ready[winner] = accept_en && |req_valid. All other req_ready bits are 0.
  - req_ready never asserts for a requester whose req_valid=0.
- On a handshake (req_valid[i] && req_ready[i]) at edge k:
  - rsp_data, rsp_err and rsp_id=i are registered at edge k.
  - rr_ptr becomes (i+1) mod NUM_REQ.
  - state becomes RESP.
  - Latency is 1 cycle: rsp_valid is high in the cycle after acceptance.
- RESP with rsp_ready=1:
  - If a new request is granted the same cycle, the output register reloads and the FSM stays in RESP. Throughput is one result per cycle.
  - Otherwise the FSM returns to IDLE and rsp_valid drops.
- RESP with rsp_ready=0: rsp_* hold stable; no req_ready asserts.
- rr_ptr changes only on a handshake.
- Fairness: a continuously asserted requester is served within NUM_REQ grants.
- Requesters must hold op/a/b stable while valid and not yet readied. The block does not check this.
- Reset mid-operation: an in-flight response is discarded, with no replay, and all state returns to reset values.
- Single-requester case: with only requester i valid, it is served every cycle while rsp_ready=1.

Decomposition:
- Package logic_unit_pkg holds:
  - the opcode enum (OP_AND=0 … OP_XNOR=6, OP_ILLEGAL=7);
  - the state enum {ST_IDLE, ST_RESP};
  - OP_W=3.
- Sub-module logic_op_unit: purely combinational, parameter WIDTH.
  - Inputs op, a, b; outputs y, err.
  - Built from vectors of primitive gate instances (and/or/not/nand/nor/xor/xnor) and a mux on op.
- The arbiter, FSM and output register stay in logic_unit_arbiter.

Test Plan:
- Reset then idle: all req_valid=0 -> rsp_valid=0, req_ready=0, rsp_data=0 for 10 cycles. Assert rst_n=0 mid-response -> rsp_valid drops immediately, asynchronously.
- Single op sweep: requester 2, a=8'hC5, b=8'h3A, ops 0..6 with rsp_ready=1. Required rsp_data = 00, FF, 3A, FF, 00, FF, 00, each with rsp_id=2, 1 cycle after its handshake.
- Round-robin: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 and rsp_valid high every cycle after the first.
- Backpressure: requester 1 (op=5, a=8'hF0, b=8'h0F) accepted, then rsp_ready=0 for 3 cycles with requester 3 valid. Required: rsp_data=FF held, rsp_id=1, req_ready=0. On release, requester 3 is granted in that same cycle.
- Illegal opcode: requester 0, op=7 -> rsp_valid=1, rsp_err=1, rsp_data=00. A following legal op (AND) -> rsp_err=0.
- Pointer wrap: requesters 3 and 0 valid, rr_ptr=3 -> grant 3 then 0, rr_ptr ends at 1.
